// File: rtl/seq_serializer_if.sv
// Handshake/serial bundle for seq_serializer: parallel word input side and the
// registered serial output side.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data;
    logic             data_valid;
    logic             frame_start;

    modport master (
        output in_valid, in_data,
        input  in_ready, data, data_valid, frame_start
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, data, data_valid, frame_start
    );
endinterface

// File: rtl/seq_serializer.sv
// Word-to-bit serializer: a small FIFO feeds an MSB-first shift register that
// emits one bit per enabled clock, chaining buffered words with no gaps.
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_en,
    seq_serializer_if.slave        bus,
    output logic                   idle,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic             push;
    logic             pop;
    logic             last_bit;

    // Pop decisions use the registered count, so a word always spends an edge in the FIFO.
    assign bus.in_ready = reset && (count != CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign last_bit     = (bitcnt == BW'(WIDTH - 1));
    assign pop          = bit_en && (count != '0) && ((state == IDLE) || last_bit);
    assign idle         = (state == IDLE) && (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            shreg           <= '0;
            bitcnt          <= '0;
            bus.data        <= 1'b0;
            bus.data_valid  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (bit_en) begin
            if (pop) begin
                shreg           <= mem[rd_ptr];
                bus.data        <= mem[rd_ptr][WIDTH-1];
                bus.data_valid  <= 1'b1;
                bus.frame_start <= 1'b1;
                bitcnt          <= '0;
                state           <= SHIFT;
            end else if ((state == SHIFT) && !last_bit) begin
                shreg           <= shreg << 1;
                bus.data        <= shreg[WIDTH-2];
                bus.frame_start <= 1'b0;
                bitcnt          <= bitcnt + BW'(1);
            end else begin
                // Last bit sent with nothing queued (or idle with an empty FIFO).
                state           <= IDLE;
                bus.data        <= 1'b0;
                bus.data_valid  <= 1'b0;
                bus.frame_start <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// Randomised and directed bench for seq_serializer against a queue-based model
// of the transmitted word stream.
module tb_seq_serializer;
    localparam int W = 8;
    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       bit_en;
    logic       idle;
    logic [2:0] count;

    int errors;
    int checks;

    // Reference model: queued words, word on the line and which bit of it is showing.
    logic [W-1:0] mq[$];
    logic [W-1:0] cur;
    int           pos;

    seq_serializer_if #(.WIDTH(W)) bus ();

    seq_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .bit_en (bit_en),
        .bus    (bus),
        .idle   (idle),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        cur = '0;
        pos = -1;
    endfunction

    function automatic void model_step(input logic v, input logic [W-1:0] d, input logic en);
        int  sz;
        bit  acc;
        sz  = mq.size();
        acc = v && (sz < D);
        if (en) begin
            if (pos >= 0 && pos < W - 1) begin
                pos++;
            end else if (sz > 0) begin
                cur = mq.pop_front();
                pos = 0;
            end else begin
                pos = -1;
            end
        end
        if (acc) mq.push_back(d);
    endfunction

    // {data, data_valid, frame_start, idle, in_ready, count}
    function automatic logic [7:0] exp_vec();
        logic e_data;
        e_data = (pos >= 0) ? cur[W-1-pos] : 1'b0;
        return {e_data, pos >= 0, pos == 0, (pos < 0) && (mq.size() == 0),
                mq.size() < D, 3'(mq.size())};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {bus.data, bus.data_valid, bus.frame_start, idle, bus.in_ready, count};
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d, input logic en);
        bus.in_valid = v;
        bus.in_data  = d;
        bit_en       = en;
        @(posedge clk);
        model_step(v, d, en);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bit_en       = 1'b1;
        reset        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 8'b0001_0000) begin
            errors++;
            $display("[TB] FAIL reset_held got=%b want=%b", obs_vec(), 8'b0001_0000);
        end
        reset = 1'b1;
        step(1'b0, '0, 1'b0);
        checks++;
        if (obs_vec() !== 8'b0001_1000) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b want=%b", obs_vec(), 8'b0001_1000);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] got;
        got = '0;
        step(1'b1, 8'hB2, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL single_edge%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i <= 8) got = {got[W-2:0], bus.data};
        end
        checks++;
        if (got !== 8'hB2) begin
            errors++;
            $display("[TB] FAIL single_bits got=%h want=%h", got, 8'hB2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int          fs_edges;
        bits     = '0;
        fs_edges = 0;
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL b2b_edge1 got=%b want=%b", obs_vec(), exp_vec());
        end
        bits = {bits[14:0], bus.data};
        if (bus.frame_start) fs_edges = fs_edges | 1;
        for (int i = 2; i <= 17; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL b2b_edge%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (i <= 16) bits = {bits[14:0], bus.data};
            if (bus.frame_start) fs_edges = fs_edges | (1 << (i - 1));
        end
        checks++;
        if (bits !== 16'hA53C) begin
            errors++;
            $display("[TB] FAIL b2b_stream got=%h want=%h", bits, 16'hA53C);
        end
        checks++;
        if (fs_edges !== ((1 << 0) | (1 << 8))) begin
            errors++;
            $display("[TB] FAIL b2b_frame_start got=%h want=%h", fs_edges, (1 << 0) | (1 << 8));
        end
    endtask

    task automatic test_backpressure();
        int           nxt;
        bit           acc;
        int           cyc;
        logic         bitq[$];
        logic [W-1:0] w;
        nxt = 1;
        for (int i = 0; i < 6; i++) begin
            acc = (nxt <= 7) && (mq.size() < D);
            step(nxt <= 7, W'(nxt), 1'b0);
            if (acc) nxt++;
        end
        checks++;
        if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_full got=count%0d/ready%b want=count4/ready0", count, bus.in_ready);
        end
        cyc = 0;
        while ((nxt <= 7 || pos >= 0 || mq.size() > 0) && cyc < 200) begin
            acc = (nxt <= 7) && (mq.size() < D);
            step(nxt <= 7, W'(nxt), 1'b1);
            if (acc) nxt++;
            cyc++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL bp_cycle%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
            if (bus.data_valid) bitq.push_back(bus.data);
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("[TB] FAIL bp_timeout got=%0d cycles want=<200", cyc);
        end
        checks++;
        if (bitq.size() != 7 * W) begin
            errors++;
            $display("[TB] FAIL bp_bitcount got=%0d want=%0d", bitq.size(), 7 * W);
        end else begin
            for (int k = 1; k <= 7; k++) begin
                for (int b = 0; b < W; b++) w = {w[W-2:0], bitq.pop_front()};
                checks++;
                if (w !== W'(k)) begin
                    errors++;
                    $display("[TB] FAIL bp_word%0d got=%h want=%h", k, w, W'(k));
                end
            end
        end
    endtask

    task automatic test_half_rate();
        int nvalid;
        int nfs;
        nvalid = 0;
        nfs    = 0;
        step(1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, '0, (i % 2) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL half_clk%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (bus.data_valid) nvalid++;
            if (bus.frame_start) nfs++;
        end
        checks++;
        if (nvalid != 16 || nfs != 2) begin
            errors++;
            $display("[TB] FAIL half_timing got=valid%0d/fs%0d want=valid16/fs2", nvalid, nfs);
        end
    endtask

    task automatic test_reset_mid_word();
        int nvalid;
        nvalid = 0;
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h81, 1'b1);
        step(1'b1, 8'h42, 1'b1);
        step(1'b0, '0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL midrst_before got=%b want=%b", obs_vec(), exp_vec());
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 8'b0001_0000) begin
            errors++;
            $display("[TB] FAIL midrst_async got=%b want=%b", obs_vec(), 8'b0001_0000);
        end
        model_reset();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL midrst_after%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
            if (bus.data_valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("[TB] FAIL midrst_silent got=%0d want=0", nvalid);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
        cyc = 0;
        while ((pos >= 0 || mq.size() > 0) && cyc < 100) begin
            step(1'b0, '0, 1'b1);
            cyc++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL drain%0d got=%b want=%b", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_idle got=%b want=1", idle);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_half_rate();
        test_reset_mid_word();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Transmit-side counterpart of the serial sequence detector. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Shifts each word out MSB-first on a single-bit serial line, one bit per enabled clock. Generates the serial `data` stream that feeds detector benches and on-chip detector instances, with no gaps between buffered words.

Parameters:
- WIDTH, 8, bits per word (2..32).
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- in_ready  output  1  FIFO can accept a word.
- bit_en  input  1  bit-rate strobe; the serializer advances only when 1. Tie to 1 for one bit per clock.
- data  output  1  serial bit out (registered).
- data_valid  output  1  data carries a live bit (registered).
- frame_start  output  1  high while data carries the MSB of a word.
- idle  output  1  FIFO empty and serializer in IDLE.
- count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs become 0, except idle=1.
  - count=0; FIFO pointers cleared; FIFO contents discarded.
  - State becomes IDLE and the shift register is cleared.
  - in_ready is forced 0 while reset=0.
- Reset mid-word: the word is abandoned immediately; no bits of it appear after reset release.
- FIFO:
  - in_ready = !full (combinational from count).
  - Push on a rising edge with in_valid && in_ready.
  - No push when full, even on a cycle that also pops.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - No bypass: a word must sit in the FIFO for at least one edge before it is loaded.
- Serializer state machine, two states (IDLE, SHIFT) plus bit counter bitcnt (0..WIDTH-1):
  - IDLE, rising edge with bit_en=1 and count!=0:
    - pop the FIFO head into the shift register;
    - data=MSB, data_valid=1, frame_start=1, bitcnt=0;
    - go to SHIFT.
  - IDLE otherwise: data=0, data_valid=0, frame_start=0.
  - SHIFT, bit_en=0: all outputs and state hold.
  - SHIFT, bit_en=1, bitcnt<WIDTH-1: shift left, data=next bit, bitcnt+1, frame_start=0.
  - SHIFT, bit_en=1, bitcnt=WIDTH-1, count!=0: pop and load the next word exactly as from IDLE; frame_start=1. This gives a gapless stream.
  - SHIFT, bit_en=1, bitcnt=WIDTH-1, count=0: data=0, data_valid=0, go to IDLE.
- Latency: a word pushed at edge E0 into an idle, empty block has its MSB on data after edge E0+1 (with bit_en=1). The last bit is present after edge E0+WIDTH.
- Each word occupies exactly WIDTH enabled cycles.
- idle = (state==IDLE) && (count==0).

Test Plan:
- Reset value check → after reset release, with no stimulus: in_ready=1, idle=1, count=0, data=0, data_valid=0, frame_start=0.
- Single word, WIDTH=8, bit_en=1, push 8'b1011_0010 at edge 0 → edges 1..8 give data=1,0,1,1,0,0,1,0; data_valid=1 for those 8 cycles; frame_start=1 only after edge 1; data_valid=0 and idle=1 after edge 9.
- Back-to-back, push 8'hA5 then 8'h3C on consecutive edges → 16 contiguous valid bits 1010_0101_0011_1100 with no gap; frame_start pulses after edges 1 and 9.
- Backpressure, DEPTH=4, in_valid held high with words 1..7 and bit_en=0 → 4 words accepted, count=4, in_ready=0. Then set bit_en=1 → a push resumes only after a pop; all words emerge in order, none lost or duplicated.
- Half rate, bit_en toggling 1,0,1,0..., push 8'hF0 → each bit held 2 clocks, 16 clocks total; frame_start stays high for both clocks of the MSB.
- Reset mid-word: assert reset=0 asynchronously (off-edge) after the 3rd bit of 8'hFF, with 2 words queued → data, data_valid and count go 0 immediately without a clock edge. After release, nothing is transmitted until a new push.
